// File: rtl/linebuf_window_ctrl.sv
// Column/row sequencer for two cascaded line buffers feeding 3x3 window filters.
// Tracks raw capture timing, drives the buffer enable and address, and flags complete windows.
module linebuf_window_ctrl #(
  parameter int unsigned NO_OF_COLS = 320,
  parameter int unsigned NO_OF_ROWS = 240,
  parameter int unsigned COL_W      = $clog2(NO_OF_COLS),
  parameter int unsigned ROW_W      = $clog2(NO_OF_ROWS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_start,
  input  logic             i_pix_valid,
  output logic             o_buf_en,
  output logic [COL_W-1:0] o_col_addr,
  output logic [ROW_W-1:0] o_row_cnt,
  output logic             o_win_valid,
  output logic             o_line_done,
  output logic             o_frame_done,
  output logic             o_busy,
  output logic             o_proto_err
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NO_OF_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NO_OF_ROWS - 1);
  // A 3x3 window needs two earlier rows and two earlier columns in the buffers.
  localparam int unsigned      WIN_LAG  = 2;

  typedef enum logic [1:0] {StIdle, StActive, StLineGap, StDone} state_t;

  state_t           r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_buf_en;
  logic [COL_W-1:0] r_col_addr;
  logic [ROW_W-1:0] r_row_cnt;
  logic             r_win_valid;
  logic             r_line_done;
  logic             r_frame_done;
  logic             r_busy;
  logic             r_proto_err;

  state_t           w_state_d;
  logic [COL_W-1:0] w_col_d;
  logic [ROW_W-1:0] w_row_d;
  logic             w_accept;
  logic             w_proto_err_d;
  logic             w_in_frame;
  logic             w_last_col;
  logic             w_last_row;

  assign w_in_frame = (r_state == StActive) || (r_state == StLineGap);
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_row = (r_row == LAST_ROW);

  always_comb begin
    w_state_d     = r_state;
    w_col_d       = r_col;
    w_row_d       = r_row;
    w_accept      = 1'b0;
    w_proto_err_d = r_proto_err;
    if (i_frame_start) begin
      // A restart mid-frame or a colliding pixel is an error; otherwise the flag clears.
      w_state_d     = StActive;
      w_col_d       = '0;
      w_row_d       = '0;
      w_proto_err_d = w_in_frame || i_pix_valid;
    end else begin
      if (i_pix_valid) begin
        if (w_in_frame) begin
          w_accept = 1'b1;
          if (w_last_col) begin
            w_col_d = '0;
            if (w_last_row) begin
              w_row_d   = '0;
              w_state_d = StDone;
            end else begin
              w_row_d   = r_row + ROW_W'(1);
              w_state_d = StLineGap;
            end
          end else begin
            w_col_d   = r_col + COL_W'(1);
            w_state_d = StActive;
          end
        end else begin
          w_proto_err_d = 1'b1;
        end
      end
      if (r_state == StDone) begin
        w_state_d = StIdle;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_col        <= '0;
      r_row        <= '0;
      r_buf_en     <= 1'b0;
      r_col_addr   <= '0;
      r_row_cnt    <= '0;
      r_win_valid  <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_col        <= w_col_d;
      r_row        <= w_row_d;
      r_buf_en     <= w_accept;
      if (w_accept) begin
        r_col_addr <= r_col;
        r_row_cnt  <= r_row;
      end
      r_win_valid  <= w_accept && (r_row >= ROW_W'(WIN_LAG)) && (r_col >= COL_W'(WIN_LAG));
      r_line_done  <= w_accept && w_last_col;
      r_frame_done <= w_accept && w_last_col && w_last_row;
      // Covers the DONE cycle so busy drops the cycle after frame_done.
      r_busy       <= (w_state_d != StIdle);
      r_proto_err  <= w_proto_err_d;
    end
  end

  assign o_buf_en     = r_buf_en;
  assign o_col_addr   = r_col_addr;
  assign o_row_cnt    = r_row_cnt;
  assign o_win_valid  = r_win_valid;
  assign o_line_done  = r_line_done;
  assign o_frame_done = r_frame_done;
  assign o_busy       = r_busy;
  assign o_proto_err  = r_proto_err;

endmodule
